// File: rtl/inst_mem_loader_if.sv
// Bundles the program-load stream, the CPU fetch port and the loader status flags.
// Latency: none here; the signals are plain wires between the two ends.
// Backpressure: s_ready from the loader is the only flow-control signal on the stream.
//
// Signals:
//   load_start/load_len     load request and its word count (sampled when load_start=1)
//   s_data/s_valid/s_ready  byte stream carrying the program, little-endian within each word
//   pc_current_address      CPU fetch word index
//   Instruction             fetched instruction word
//   cpu_run                 high when the CPU may execute and fetches are served from memory
//   load_done               one-cycle pulse when a load completes
//   load_err                sticky flag for a rejected load request
interface inst_mem_loader_if;
  logic        load_start;
  logic [6:0]  load_len;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  pc_current_address;
  logic [31:0] Instruction;
  logic        cpu_run;
  logic        load_done;
  logic        load_err;

  modport slave (
    input  load_start, load_len, s_data, s_valid, pc_current_address,
    output s_ready, Instruction, cpu_run, load_done, load_err
  );

  modport master (
    output load_start, load_len, s_data, s_valid, pc_current_address,
    input  s_ready, Instruction, cpu_run, load_done, load_err
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Loads a program from a byte stream into instruction memory and then serves CPU fetches from it.
// Latency: a word is written on the edge taking its 4th byte and can be fetched from the next cycle.
// Backpressure: s_ready is high for the whole LOAD state; a byte is taken on any edge with s_valid=1.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         inst_mem_loader_if.slave: load request, byte stream, fetch port, status flags
module inst_mem_loader #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h00000033
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_mem_loader_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [6:0]  word_cnt;
  logic [6:0]  len_q;
  logic [23:0] partial;      // bytes 0..2 of the word being assembled
  logic        s_ready_q;
  logic        cpu_run_q;
  logic        load_done_q;
  logic        load_err_q;

  // Storage has no reset, so program contents survive a reset.
  logic [31:0] mem [DEPTH];

  logic          len_ok;
  logic          accept;
  logic          word_done;
  logic          last_word;
  logic [31:0]   wr_word;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign len_ok    = (bus.load_len != 7'd0) && (32'(bus.load_len) <= DEPTH);
  // s_ready is high exactly when in LOAD, so the state stands in for it here.
  assign accept    = (state == LOAD) && bus.s_valid;
  assign word_done = accept && (byte_cnt == 2'd3);
  assign last_word = ((word_cnt + 7'd1) == len_q);
  // The 4th byte goes straight into the top lane of the word being written.
  assign wr_word   = {bus.s_data, partial};
  assign wr_idx    = AW'(word_cnt);
  assign rd_idx    = AW'(bus.pc_current_address);

  always_ff @(posedge clk) begin
    if (word_done) begin
      mem[wr_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_cnt    <= 2'd0;
      word_cnt    <= 7'd0;
      len_q       <= 7'd0;
      partial     <= 24'd0;
      s_ready_q   <= 1'b0;
      cpu_run_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (bus.load_start) begin
            if (len_ok) begin
              state      <= LOAD;
              byte_cnt   <= 2'd0;
              word_cnt   <= 7'd0;
              len_q      <= bus.load_len;
              partial    <= 24'd0;
              s_ready_q  <= 1'b1;
              cpu_run_q  <= 1'b0;
              load_err_q <= 1'b0;
            end else begin
              // Bad length: stay where we are, RUN keeps executing the old program.
              load_err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          // load_start is deliberately not looked at while loading.
          if (accept) begin
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              partial  <= 24'd0;
              word_cnt <= word_cnt + 7'd1;
              if (last_word) begin
                state       <= RUN;
                s_ready_q   <= 1'b0;
                cpu_run_q   <= 1'b1;
                load_done_q <= 1'b1;
              end
            end else begin
              case (byte_cnt)
                2'd0:    partial[7:0]   <= bus.s_data;
                2'd1:    partial[15:8]  <= bus.s_data;
                default: partial[23:16] <= bus.s_data;
              endcase
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          s_ready_q <= 1'b0;
          cpu_run_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.cpu_run     = cpu_run_q;
  assign bus.load_done   = load_done_q;
  assign bus.load_err    = load_err_q;
  assign bus.Instruction = (cpu_run_q && (32'(bus.pc_current_address) < DEPTH)) ?
                           mem[rd_idx] : NOP_WORD;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: loads, gapped loads, bad lengths, reloads and resets.
// Latency: outputs are sampled 1 time unit after the rising edge that produced them.
// Backpressure: the stream is driven one byte per accepted cycle, with optional idle gaps.
module tb_inst_mem_loader;

  localparam logic [31:0] NOP = 32'h00000033;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_mem_loader_if bus();

  inst_mem_loader #(.DEPTH(64), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  int          tests    = 0;
  int          fails    = 0;
  int          done_cnt = 0;
  exp_t        sbq[$];
  logic [31:0] model [64];
  logic [7:0]  prog[$];

  always @(posedge clk) if (bus.load_done) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a load of len words from prog; optionally raise load_start on byte 1
  // (len 0) and on the final byte (len 1), both of which must be ignored.
  task automatic do_load(input int len, input int gap, input bit mid_start, input bit fin_start);
    int d0;
    bus.load_len   = 7'(len);
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    bus.load_len   = 7'd0;
    chk("start_s_ready", 32'(bus.s_ready), 32'd1);
    chk("start_cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("start_err_clr", 32'(bus.load_err), 32'd0);
    d0 = done_cnt;
    for (int i = 0; i < prog.size(); i++) begin
      bus.s_data  = prog[i];
      bus.s_valid = 1'b1;
      if (mid_start && i == 1) begin
        bus.load_start = 1'b1;
        bus.load_len   = 7'd0;
      end
      if (fin_start && i == prog.size() - 1) begin
        bus.load_start = 1'b1;
        bus.load_len   = 7'd1;
      end
      tick;
      bus.s_valid    = 1'b0;
      bus.load_start = 1'b0;
      bus.load_len   = 7'd0;
      if (i % 4 == 3) begin
        model[i/4] = {prog[i], prog[i-1], prog[i-2], prog[i-3]};
        sbq.push_back('{8'(i/4), model[i/4]});
      end
      if (i != prog.size() - 1) begin
        chk("load_s_ready", 32'(bus.s_ready), 32'd1);
        chk("load_fetch_nop", bus.Instruction, NOP);
        repeat (gap) begin
          tick;
          chk("gap_s_ready", 32'(bus.s_ready), 32'd1);
        end
      end
    end
    chk("done_pulse", 32'(bus.load_done), 32'd1);
    chk("done_cpu_run", 32'(bus.cpu_run), 32'd1);
    chk("done_s_ready", 32'(bus.s_ready), 32'd0);
    chk("done_err", 32'(bus.load_err), 32'd0);
    tick;
    chk("done_clear", 32'(bus.load_done), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic verify;
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      bus.pc_current_address = e.addr;
      #1;
      chk("fetch_word", bus.Instruction, e.data);
    end
  endtask

  task automatic check_reset_outputs;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_load_err", 32'(bus.load_err), 32'd0);
    chk("rst_fetch_nop", bus.Instruction, NOP);
  endtask

  initial begin
    bus.load_start         = 1'b0;
    bus.load_len           = 7'd0;
    bus.s_data             = 8'd0;
    bus.s_valid            = 1'b0;
    bus.pc_current_address = 8'd1;

    // Reset state
    #2;
    check_reset_outputs();
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    // Two-word load, back-to-back bytes
    prog = '{8'h37, 8'h03, 8'h71, 8'h02, 8'h97, 8'h83, 8'h00, 8'h00};
    bus.pc_current_address = 8'd1;
    do_load(2, 0, 1'b0, 1'b0);
    bus.pc_current_address = 8'd1;
    #1;
    chk("pc1_word", bus.Instruction, 32'h00008397);
    bus.pc_current_address = 8'd0;
    #1;
    chk("pc0_word", bus.Instruction, 32'h02710337);
    verify();
    bus.pc_current_address = 8'd70;
    #1;
    chk("run_oob_nop", bus.Instruction, NOP);

    // Same load from RUN with 3 idle cycles between bytes
    bus.pc_current_address = 8'd1;
    do_load(2, 3, 1'b0, 1'b0);
    verify();

    // Reset, then rejected lengths in IDLE
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick;
    rst_n = 1'b1;
    tick;
    bus.load_len   = 7'd0;
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    chk("len0_err", 32'(bus.load_err), 32'd1);
    chk("len0_s_ready", 32'(bus.s_ready), 32'd0);
    chk("len0_cpu_run", 32'(bus.cpu_run), 32'd0);
    tick;
    bus.load_len   = 7'd65;
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    bus.load_len   = 7'd0;
    chk("len65_err", 32'(bus.load_err), 32'd1);
    chk("len65_s_ready", 32'(bus.s_ready), 32'd0);
    tick;
    chk("err_sticky", 32'(bus.load_err), 32'd1);
    chk("err_idle_s_ready", 32'(bus.s_ready), 32'd0);

    // Valid one-word load clears the error; word 1 keeps its old contents
    prog = '{8'h13, 8'h05, 8'h10, 8'h00};
    bus.pc_current_address = 8'd1;
    do_load(1, 0, 1'b0, 1'b0);
    sbq.push_back('{8'd1, model[1]});
    verify();

    // Reload from RUN; ignored load_start mid-load and on the final byte
    prog = '{8'h93, 8'h00, 8'h50, 8'h00};
    bus.pc_current_address = 8'd1;
    do_load(1, 0, 1'b1, 1'b1);
    sbq.push_back('{8'd1, model[1]});
    chk("reload_cpu_run", 32'(bus.cpu_run), 32'd1);
    chk("reload_s_ready", 32'(bus.s_ready), 32'd0);
    verify();

    // Reset after 5 bytes of a 2-word load
    bus.load_len   = 7'd2;
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    bus.load_len   = 7'd0;
    prog = '{8'h37, 8'h03, 8'h71, 8'h02, 8'h97};
    for (int i = 0; i < 5; i++) begin
      bus.s_data  = prog[i];
      bus.s_valid = 1'b1;
      tick;
    end
    bus.s_valid = 1'b0;
    model[0] = 32'h02710337;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    tick;
    rst_n = 1'b1;
    tick;

    // Load after reset works; the partial second word never reached storage
    prog = '{8'hef, 8'hbe, 8'had, 8'hde};
    bus.pc_current_address = 8'd1;
    do_load(1, 0, 1'b0, 1'b0);
    sbq.push_back('{8'd1, model[1]});
    verify();
    bus.pc_current_address = 8'd0;
    #1;
    chk("post_rst_word0", bus.Instruction, 32'hdeadbeef);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
